// File: rtl/issue_stage_pkg.sv
// issue_stage_pkg: shared definitions for the issue stage.
//   unit_e   - functional-unit encoding carried with each decoded instruction
//   ROW_WB   - scoreboard stage vector of a value that is in writeback and
//              can therefore be forwarded instead of stalling
//   is_claim - true when an instruction must reserve its destination register
package issue_stage_pkg;

  typedef enum logic [1:0] {
    UNIT_AM      = 2'b00,
    UNIT_MEM     = 2'b01,
    UNIT_MULT    = 2'b10,
    UNIT_ILLEGAL = 2'b11
  } unit_e;

  localparam logic [4:0] ROW_WB = 5'b00001;

  // r0 is hardwired, so writing it never needs a scoreboard reservation.
  function automatic logic is_claim(input logic writes_rd, input logic [4:0] rd);
    return writes_rd && (rd != 5'd0);
  endfunction

endpackage

// File: rtl/issue_stage_if.sv
// issue_stage_if: Decode -> Issue handshake.
//   valid/ready          - instruction offer and acceptance
//   rs, rt, rd           - source and destination register numbers
//   uses_rs, uses_rt     - source operand use flags
//   writes_rd            - instruction writes back to rd
//   unit                 - target functional unit (unit_e encoding)
//   payload              - opaque instruction payload
// master: Decode side; slave: issue stage side.
interface issue_stage_if #(
  parameter int PAYLOAD_W = 32
);
  logic                 valid;
  logic                 ready;
  logic [4:0]           rs;
  logic [4:0]           rt;
  logic [4:0]           rd;
  logic                 uses_rs;
  logic                 uses_rt;
  logic                 writes_rd;
  logic [1:0]           unit;
  logic [PAYLOAD_W-1:0] payload;

  modport master (
    output valid, rs, rt, rd, uses_rs, uses_rt, writes_rd, unit, payload,
    input  ready
  );

  modport slave (
    input  valid, rs, rt, rd, uses_rs, uses_rt, writes_rd, unit, payload,
    output ready
  );
endinterface

// File: rtl/issue_stage_operand_ready.sv
// operand_ready: combinational RAW check for one source operand.
//   use_src  in  operand is read by the instruction
//   reg_src  in  register number of the operand
//   pending  in  scoreboard pending bit for reg_src
//   row      in  scoreboard stage vector for reg_src
//   ready    out operand value is available (or forwardable) this cycle
module operand_ready
  import issue_stage_pkg::*;
(
  input  logic       use_src,
  input  logic [4:0] reg_src,
  input  logic       pending,
  input  logic [4:0] row,
  output logic       ready
);

  // A producer sitting in writeback is forwarded, so it does not block.
  assign ready = !use_src || (reg_src == 5'd0) || !pending || (row == ROW_WB);

endmodule

// File: rtl/issue_stage.sv
// issue_stage: single-entry in-order issue stage between Decode and the
// AluMisc, Mem and Mult units. Holds one decoded instruction, checks RAW and
// writeback-collision hazards against the scoreboard, claims the destination
// and sends a registered one-cycle dispatch pulse to the target unit.
//   clock, reset                  clock; synchronous active-low reset
//   id                            Decode handshake (issue_stage_if.slave)
//   iss_ass_addr_a/b              scoreboard read addresses (held rs, rt)
//   iss_ass_pending_a/b, _row_a/b scoreboard read data per operand
//   sb_haz_column                 writeback-collision column for registerunit
//   writeaddr, registerunit,
//   enablewrite                   scoreboard claim port
//   am/mem/mult_ready             unit can accept
//   am/mem/mult_valid             registered dispatch pulses
//   ex_payload, ex_rd             registered payload/destination of last dispatch
//   flush                         discard the held instruction
//   stall_count                   consecutive stall cycles, saturating
//   illegal_unit                  sticky: an instruction targeted unit 11
module issue_stage
  import issue_stage_pkg::*;
#(
  parameter int PAYLOAD_W = 32,
  parameter int CNT_W     = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  issue_stage_if.slave         id,
  output logic [4:0]           iss_ass_addr_a,
  output logic [4:0]           iss_ass_addr_b,
  input  logic                 iss_ass_pending_a,
  input  logic                 iss_ass_pending_b,
  input  logic [4:0]           iss_ass_row_a,
  input  logic [4:0]           iss_ass_row_b,
  input  logic [31:0]          sb_haz_column,
  output logic [4:0]           writeaddr,
  output logic [1:0]           registerunit,
  output logic                 enablewrite,
  input  logic                 am_ready,
  input  logic                 mem_ready,
  input  logic                 mult_ready,
  output logic                 am_valid,
  output logic                 mem_valid,
  output logic                 mult_valid,
  output logic [PAYLOAD_W-1:0] ex_payload,
  output logic [4:0]           ex_rd,
  input  logic                 flush,
  output logic [CNT_W-1:0]     stall_count,
  output logic                 illegal_unit
);

  logic                 hvalid;
  logic [4:0]           h_rs;
  logic [4:0]           h_rt;
  logic [4:0]           h_rd;
  logic                 h_uses_rs;
  logic                 h_uses_rt;
  logic                 h_writes_rd;
  unit_e                h_unit;
  logic [PAYLOAD_W-1:0] h_payload;

  logic opa_ready;
  logic opb_ready;
  logic claim;
  logic struct_haz;
  logic unit_rdy;
  logic live;
  logic issue;
  logic drop_illegal;

  operand_ready u_opa (
    .use_src (h_uses_rs),
    .reg_src (h_rs),
    .pending (iss_ass_pending_a),
    .row     (iss_ass_row_a),
    .ready   (opa_ready)
  );

  operand_ready u_opb (
    .use_src (h_uses_rt),
    .reg_src (h_rt),
    .pending (iss_ass_pending_b),
    .row     (iss_ass_row_b),
    .ready   (opb_ready)
  );

  always_comb begin
    unit_rdy = 1'b0;
    case (h_unit)
      UNIT_AM:   unit_rdy = am_ready;
      UNIT_MEM:  unit_rdy = mem_ready;
      UNIT_MULT: unit_rdy = mult_ready;
      default:   unit_rdy = 1'b0;
    endcase
  end

  assign claim      = is_claim(h_writes_rd, h_rd);
  // Mult has no fixed writeback slot, so its column is never consulted.
  assign struct_haz = claim && (h_unit != UNIT_MULT) && (|sb_haz_column);

  // Gating with reset keeps a held instruction from claiming on the reset edge.
  assign live         = hvalid && reset && !flush;
  assign issue        = live && (h_unit != UNIT_ILLEGAL) && opa_ready && opb_ready
                        && !struct_haz && unit_rdy;
  assign drop_illegal = live && (h_unit == UNIT_ILLEGAL);

  assign id.ready       = !hvalid || flush || issue || drop_illegal;
  assign iss_ass_addr_a = h_rs;
  assign iss_ass_addr_b = h_rt;
  assign writeaddr      = h_rd;
  assign registerunit   = hvalid ? h_unit : UNIT_AM;
  assign enablewrite    = issue && claim;

  always_ff @(posedge clock) begin
    if (!reset) begin
      hvalid <= 1'b0;
    end else if (flush) begin
      hvalid <= 1'b0;
    end else if (id.ready) begin
      hvalid <= id.valid;
    end
  end

  always_ff @(posedge clock) begin
    if (id.ready && id.valid && !flush) begin
      h_rs        <= id.rs;
      h_rt        <= id.rt;
      h_rd        <= id.rd;
      h_uses_rs   <= id.uses_rs;
      h_uses_rt   <= id.uses_rt;
      h_writes_rd <= id.writes_rd;
      h_unit      <= unit_e'(id.unit);
      h_payload   <= id.payload;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      am_valid   <= 1'b0;
      mem_valid  <= 1'b0;
      mult_valid <= 1'b0;
      ex_payload <= '0;
      ex_rd      <= '0;
    end else begin
      am_valid   <= issue && (h_unit == UNIT_AM);
      mem_valid  <= issue && (h_unit == UNIT_MEM);
      mult_valid <= issue && (h_unit == UNIT_MULT);
      if (issue) begin
        ex_payload <= h_payload;
        ex_rd      <= h_rd;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (!hvalid || issue || flush) begin
      stall_count <= '0;
    end else if (stall_count != {CNT_W{1'b1}}) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      illegal_unit <= 1'b0;
    end else if (drop_illegal) begin
      illegal_unit <= 1'b1;
    end
  end

endmodule

// File: tb/tb_issue_stage.sv
// tb_issue_stage: randomized bench for issue_stage with a behavioural
// single-slot reference model and a dispatch scoreboard queue.
module tb_issue_stage;
  import issue_stage_pkg::*;

  localparam int PW     = 32;
  localparam int CW     = 4;
  localparam int NCYC   = 3000;
  localparam int SATMAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [4:0]    iss_ass_addr_a, iss_ass_addr_b;
  logic          iss_ass_pending_a, iss_ass_pending_b;
  logic [4:0]    iss_ass_row_a, iss_ass_row_b;
  logic [31:0]   sb_haz_column;
  logic [4:0]    writeaddr;
  logic [1:0]    registerunit;
  logic          enablewrite;
  logic          am_ready, mem_ready, mult_ready;
  logic          am_valid, mem_valid, mult_valid;
  logic [PW-1:0] ex_payload;
  logic [4:0]    ex_rd;
  logic          flush;
  logic [CW-1:0] stall_count;
  logic          illegal_unit;

  always #5 clock = ~clock;

  issue_stage_if #(.PAYLOAD_W(PW)) id_if ();

  issue_stage #(.PAYLOAD_W(PW), .CNT_W(CW)) dut (
    .clock             (clock),
    .reset             (reset),
    .id                (id_if),
    .iss_ass_addr_a    (iss_ass_addr_a),
    .iss_ass_addr_b    (iss_ass_addr_b),
    .iss_ass_pending_a (iss_ass_pending_a),
    .iss_ass_pending_b (iss_ass_pending_b),
    .iss_ass_row_a     (iss_ass_row_a),
    .iss_ass_row_b     (iss_ass_row_b),
    .sb_haz_column     (sb_haz_column),
    .writeaddr         (writeaddr),
    .registerunit      (registerunit),
    .enablewrite       (enablewrite),
    .am_ready          (am_ready),
    .mem_ready         (mem_ready),
    .mult_ready        (mult_ready),
    .am_valid          (am_valid),
    .mem_valid         (mem_valid),
    .mult_valid        (mult_valid),
    .ex_payload        (ex_payload),
    .ex_rd             (ex_rd),
    .flush             (flush),
    .stall_count       (stall_count),
    .illegal_unit      (illegal_unit)
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [1:0]  unit;
    logic [31:0] payload;
    logic [4:0]  rd;
  } disp_t;

  disp_t exp_q[$];

  // reference model: the one held instruction plus architectural expectations
  bit          m_v = 1'b0;
  logic [4:0]  m_rs, m_rt, m_rd;
  bit          m_urs, m_urt, m_wrd;
  logic [1:0]  m_unit;
  logic [31:0] m_pay;
  int          exp_stall = 0;
  bit          exp_ill = 1'b0;
  logic [31:0] last_payload = '0;
  logic [4:0]  last_rd = '0;
  bit          started = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] rand_row();
    int k;
    k = $urandom_range(0, 3);
    if (k == 0) return 5'b00001;
    if (k == 1) return 5'b00000;
    return 5'b00001 << $urandom_range(1, 4);
  endfunction

  // monitor: every registered dispatch is matched against the scoreboard queue
  always @(negedge clock) begin
    int    nv;
    disp_t d;
    logic [1:0] got_unit;
    if (started) begin
      chk("stall_count", 64'(stall_count), 64'(exp_stall));
      chk("illegal_unit", 64'(illegal_unit), 64'(exp_ill));
      nv = int'(am_valid) + int'(mem_valid) + int'(mult_valid);
      if (nv != 0) begin
        chk("dispatch_onehot", 64'(nv), 64'd1);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_dispatch: got valids %b%b%b expected none at %0t",
                   am_valid, mem_valid, mult_valid, $time);
        end else begin
          d = exp_q.pop_front();
          got_unit = mult_valid ? 2'b10 : (mem_valid ? 2'b01 : 2'b00);
          chk("dispatch_unit", 64'(got_unit), 64'(d.unit));
          last_payload = d.payload;
          last_rd      = d.rd;
        end
      end else begin
        chk("dispatch_outstanding", 64'(exp_q.size()), 64'd0);
      end
      chk("ex_payload", 64'(ex_payload), 64'(last_payload));
      chk("ex_rd", 64'(ex_rd), 64'(last_rd));
    end
  end

  initial begin
    bit   opa, opb, claim, haz, urdy, issue, cons, e_ready;
    int   phase;
    id_if.valid = 1'b0; id_if.rs = '0; id_if.rt = '0; id_if.rd = '0;
    id_if.uses_rs = 1'b0; id_if.uses_rt = 1'b0; id_if.writes_rd = 1'b0;
    id_if.unit = 2'b00; id_if.payload = '0;
    iss_ass_pending_a = 1'b0; iss_ass_pending_b = 1'b0;
    iss_ass_row_a = '0; iss_ass_row_b = '0; sb_haz_column = '0;
    am_ready = 1'b0; mem_ready = 1'b0; mult_ready = 1'b0; flush = 1'b0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_am_valid", 64'(am_valid), 64'd0);
    chk("rst_mem_valid", 64'(mem_valid), 64'd0);
    chk("rst_mult_valid", 64'(mult_valid), 64'd0);
    chk("rst_stall_count", 64'(stall_count), 64'd0);
    chk("rst_illegal_unit", 64'(illegal_unit), 64'd0);
    chk("rst_ex_payload", 64'(ex_payload), 64'd0);
    chk("rst_ex_rd", 64'(ex_rd), 64'd0);
    chk("rst_id_ready", 64'(id_if.ready), 64'd1);
    chk("rst_enablewrite", 64'(enablewrite), 64'd0);
    started = 1'b1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      phase = (cyc / 250) % 3;
      reset = (cyc < 2) ? 1'b1 : ($urandom_range(0, 199) != 0);
      flush = (phase == 1) ? ($urandom_range(0, 63) == 0) : ($urandom_range(0, 15) == 0);
      id_if.valid     = ($urandom_range(0, 3) != 0);
      id_if.rs        = 5'($urandom_range(0, 31));
      id_if.rt        = 5'($urandom_range(0, 31));
      id_if.rd        = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      id_if.uses_rs   = $urandom_range(0, 1);
      id_if.uses_rt   = $urandom_range(0, 1);
      id_if.writes_rd = ($urandom_range(0, 3) != 0);
      id_if.unit      = ($urandom_range(0, 19) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      id_if.payload   = $urandom;
      iss_ass_pending_a = (phase == 2) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      iss_ass_pending_b = (phase == 2) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      iss_ass_row_a = rand_row();
      iss_ass_row_b = rand_row();
      if (m_v && m_unit == 2'b10)
        sb_haz_column = '0;
      else if ($urandom_range(0, (phase == 2) ? 1 : 5) == 0)
        sb_haz_column = 32'h1 << $urandom_range(0, 31);
      else
        sb_haz_column = '0;
      if (phase == 1) begin
        am_ready   = ($urandom_range(0, 19) == 0);
        mem_ready  = ($urandom_range(0, 19) == 0);
        mult_ready = ($urandom_range(0, 19) == 0);
      end else begin
        am_ready   = ($urandom_range(0, 3) != 0);
        mem_ready  = ($urandom_range(0, 3) != 0);
        mult_ready = ($urandom_range(0, 3) != 0);
      end
      #1;

      opa   = !m_urs || m_rs == 5'd0 || !iss_ass_pending_a || iss_ass_row_a == 5'b00001;
      opb   = !m_urt || m_rt == 5'd0 || !iss_ass_pending_b || iss_ass_row_b == 5'b00001;
      claim = m_wrd && m_rd != 5'd0;
      case (m_unit)
        2'b00:   urdy = am_ready;
        2'b01:   urdy = mem_ready;
        2'b10:   urdy = mult_ready;
        default: urdy = 1'b0;
      endcase
      haz     = claim && m_unit != 2'b10 && sb_haz_column != 32'd0;
      issue   = reset && m_v && !flush && m_unit != 2'b11 && opa && opb && !haz && urdy;
      cons    = reset && m_v && !flush && m_unit == 2'b11;
      e_ready = !m_v || flush || issue || cons;

      chk("id_ready", 64'(id_if.ready), 64'(e_ready));
      chk("enablewrite", 64'(enablewrite), 64'(issue && claim));
      if (m_v) begin
        chk("registerunit", 64'(registerunit), 64'(m_unit));
        chk("writeaddr", 64'(writeaddr), 64'(m_rd));
        chk("iss_ass_addr_a", 64'(iss_ass_addr_a), 64'(m_rs));
        chk("iss_ass_addr_b", 64'(iss_ass_addr_b), 64'(m_rt));
      end
      if (issue) exp_q.push_back('{m_unit, m_pay, m_rd});

      if (!reset) begin
        m_v = 1'b0;
        exp_stall = 0;
        exp_ill = 1'b0;
        last_payload = '0;
        last_rd = '0;
      end else begin
        if (!m_v || issue || flush) exp_stall = 0;
        else if (exp_stall < SATMAX) exp_stall++;
        if (cons) exp_ill = 1'b1;
        if (flush) begin
          m_v = 1'b0;
        end else if (e_ready) begin
          m_v = id_if.valid;
          if (id_if.valid) begin
            m_rs = id_if.rs; m_rt = id_if.rt; m_rd = id_if.rd;
            m_urs = id_if.uses_rs; m_urt = id_if.uses_rt; m_wrd = id_if.writes_rd;
            m_unit = id_if.unit; m_pay = id_if.payload;
          end
        end
      end
      @(negedge clock);
    end

    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
